// File: rtl/biquad_mc_engine_if.sv
// rtl/biquad_mc_engine_if.sv - sample, output and coefficient bus of the multi-channel biquad engine
//
// Purpose: bundles the input handshake, output handshake, coefficient/clear
// controls and busy status so the engine and its client share one port.
// Ports (master = client side, slave = engine side):
//   in_valid/in_ready/in_data/in_ch          input sample handshake
//   out_valid/out_ready/out_data/out_ch/out_sat  filtered sample handshake
//   coef_we/coef_ch/coef_sel/coef_data       coefficient write port
//   clear_ch                                 history clear of channel coef_ch
//   busy                                     engine not idle
interface biquad_mc_engine_if #(
   parameter int SAMPLE_WIDTH = 24,
   parameter int COEF_WIDTH   = 24,
   parameter int CH_W         = 2
);
   logic                           in_valid;
   logic                           in_ready;
   logic signed [SAMPLE_WIDTH-1:0] in_data;
   logic [CH_W-1:0]                in_ch;
   logic                           out_valid;
   logic                           out_ready;
   logic signed [SAMPLE_WIDTH-1:0] out_data;
   logic [CH_W-1:0]                out_ch;
   logic                           out_sat;
   logic                           coef_we;
   logic [CH_W-1:0]                coef_ch;
   logic [2:0]                     coef_sel;
   logic signed [COEF_WIDTH-1:0]   coef_data;
   logic                           clear_ch;
   logic                           busy;

   modport master (
      output in_valid, in_data, in_ch, out_ready,
      output coef_we, coef_ch, coef_sel, coef_data, clear_ch,
      input  in_ready, out_valid, out_data, out_ch, out_sat, busy
   );

   modport slave (
      input  in_valid, in_data, in_ch, out_ready,
      input  coef_we, coef_ch, coef_sel, coef_data, clear_ch,
      output in_ready, out_valid, out_data, out_ch, out_sat, busy
   );
endinterface

// File: rtl/biquad_mc_engine.sv
// rtl/biquad_mc_engine.sv - time-multiplexed multi-channel Direct-Form-I biquad engine
//
// Purpose: one shared signed MAC evaluates
//   y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2
// for NUM_CH channels, each with its own coefficients and history. One sample
// is in flight at a time: IDLE (accept) -> MAC (5 taps) -> SAT (round, clamp,
// commit history) -> OUT (hold until taken).
// Ports:
//   sample_clock  clock, rising edge
//   reset         synchronous, active-low
//   bus           biquad_mc_engine_if slave (samples, results, coefficients)
module biquad_mc_engine #(
   parameter int SAMPLE_WIDTH = 24,
   parameter int COEF_WIDTH   = 24,
   parameter int FRAC_BITS    = 16,
   parameter int NUM_CH       = 4,
   parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input logic               sample_clock,
   input logic               reset,
   biquad_mc_engine_if.slave bus
);
   localparam int PROD_W = SAMPLE_WIDTH + COEF_WIDTH;
   localparam int ACC_W  = PROD_W + 3;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MAC  = 2'd1;
   localparam logic [1:0] SAT  = 2'd2;
   localparam logic [1:0] OUT  = 2'd3;

   localparam logic signed [COEF_WIDTH-1:0] B0_ONE = {{(COEF_WIDTH-1){1'b0}}, 1'b1} << FRAC_BITS;
   localparam logic signed [ACC_W-1:0] RND = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_BITS-1);
   localparam logic signed [ACC_W-1:0] LIM_HI = {{(ACC_W-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] LIM_LO = {{(ACC_W-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};
   localparam logic signed [SAMPLE_WIDTH-1:0] OUT_HI = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
   localparam logic signed [SAMPLE_WIDTH-1:0] OUT_LO = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

   logic [1:0]                     state;
   logic [2:0]                     tap;
   logic [CH_W-1:0]                cur_ch;
   logic signed [SAMPLE_WIDTH-1:0] x_cur;
   logic signed [ACC_W-1:0]        acc;

   // coef[c][0..4] = b0, b1, b2, a1, a2
   logic signed [COEF_WIDTH-1:0]   coef [NUM_CH][5];
   logic signed [SAMPLE_WIDTH-1:0] x1 [NUM_CH];
   logic signed [SAMPLE_WIDTH-1:0] x2 [NUM_CH];
   logic signed [SAMPLE_WIDTH-1:0] y1 [NUM_CH];
   logic signed [SAMPLE_WIDTH-1:0] y2 [NUM_CH];

   logic signed [COEF_WIDTH-1:0]   coef_op;
   logic signed [SAMPLE_WIDTH-1:0] data_op;
   logic                           neg;
   logic signed [PROD_W-1:0]       prod;
   logic signed [ACC_W-1:0]        prod_ext;
   logic signed [ACC_W-1:0]        rounded;
   logic signed [SAMPLE_WIDTH-1:0] sat_val;
   logic                           sat_flag;
   logic [CH_W-1:0]                in_ch_eff;
   logic                           coef_ch_ok;

   // Out-of-range channels (non-power-of-two NUM_CH) fold onto channel 0.
   assign in_ch_eff  = (int'(bus.in_ch) < NUM_CH) ? bus.in_ch : '0;
   assign coef_ch_ok = (int'(bus.coef_ch) < NUM_CH);

   always_comb begin
      coef_op = '0;
      data_op = '0;
      neg     = 1'b0;
      case (tap)
         3'd0: begin coef_op = coef[cur_ch][0]; data_op = x_cur;      end
         3'd1: begin coef_op = coef[cur_ch][1]; data_op = x1[cur_ch]; end
         3'd2: begin coef_op = coef[cur_ch][2]; data_op = x2[cur_ch]; end
         3'd3: begin coef_op = coef[cur_ch][3]; data_op = y1[cur_ch]; neg = 1'b1; end
         3'd4: begin coef_op = coef[cur_ch][4]; data_op = y2[cur_ch]; neg = 1'b1; end
         default: begin coef_op = '0; data_op = '0; end
      endcase
      prod     = $signed({{SAMPLE_WIDTH{coef_op[COEF_WIDTH-1]}}, coef_op}) *
                 $signed({{COEF_WIDTH{data_op[SAMPLE_WIDTH-1]}}, data_op});
      prod_ext = {{3{prod[PROD_W-1]}}, prod};
   end

   // Round half up, then clamp to the sample range.
   always_comb begin
      rounded  = (acc + RND) >>> FRAC_BITS;
      sat_val  = rounded[SAMPLE_WIDTH-1:0];
      sat_flag = 1'b0;
      if (rounded > LIM_HI) begin
         sat_val  = OUT_HI;
         sat_flag = 1'b1;
      end else if (rounded < LIM_LO) begin
         sat_val  = OUT_LO;
         sat_flag = 1'b1;
      end
   end

   always_ff @(posedge sample_clock) begin
      if (!reset) begin
         state        <= IDLE;
         tap          <= '0;
         cur_ch       <= '0;
         x_cur        <= '0;
         acc          <= '0;
         bus.out_data <= '0;
         bus.out_ch   <= '0;
         bus.out_sat  <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            x1[c]      <= '0;
            x2[c]      <= '0;
            y1[c]      <= '0;
            y2[c]      <= '0;
            coef[c][0] <= B0_ONE;
            for (int k = 1; k < 5; k++) coef[c][k] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               // Write and clear land at the accept edge, so a sample accepted
               // in the same cycle already sees them.
               if (bus.coef_we && coef_ch_ok && (bus.coef_sel <= 3'd4))
                  coef[bus.coef_ch][bus.coef_sel] <= bus.coef_data;
               if (bus.clear_ch && coef_ch_ok) begin
                  x1[bus.coef_ch] <= '0;
                  x2[bus.coef_ch] <= '0;
                  y1[bus.coef_ch] <= '0;
                  y2[bus.coef_ch] <= '0;
               end
               if (bus.in_valid) begin
                  x_cur  <= bus.in_data;
                  cur_ch <= in_ch_eff;
                  tap    <= '0;
                  acc    <= '0;
                  state  <= MAC;
               end
            end
            MAC: begin
               acc <= neg ? (acc - prod_ext) : (acc + prod_ext);
               if (tap == 3'd4) state <= SAT;
               else             tap   <= tap + 3'd1;
            end
            SAT: begin
               x2[cur_ch]   <= x1[cur_ch];
               x1[cur_ch]   <= x_cur;
               y2[cur_ch]   <= y1[cur_ch];
               y1[cur_ch]   <= sat_val;
               bus.out_data <= sat_val;
               bus.out_ch   <= cur_ch;
               bus.out_sat  <= sat_flag;
               state        <= OUT;
            end
            OUT: begin
               if (bus.out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == OUT);
   assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_biquad_mc_engine.sv
// tb/tb_biquad_mc_engine.sv - self-checking bench for biquad_mc_engine
module tb_biquad_mc_engine;
   localparam int NCH = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   biquad_mc_engine_if #(.SAMPLE_WIDTH(24), .COEF_WIDTH(24), .CH_W(2)) bus ();

   biquad_mc_engine #(
      .SAMPLE_WIDTH(24), .COEF_WIDTH(24), .FRAC_BITS(16), .NUM_CH(NCH)
   ) dut (
      .sample_clock(clk),
      .reset(reset),
      .bus(bus)
   );

   int tests = 0;
   int fails = 0;

   typedef struct {
      int     ch;
      longint y;
      bit     sat;
   } exp_t;
   exp_t exp_q[$];

   // Reference filter: plain integer arithmetic on the difference equation.
   longint mc [NCH][5];
   longint hx1 [NCH];
   longint hx2 [NCH];
   longint hy1 [NCH];
   longint hy2 [NCH];

   task automatic check(input string name, input longint act, input longint req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic longint sext24(input longint v);
      return ((v & 64'hFFFFFF) ^ 64'h800000) - 64'h800000;
   endfunction

   function automatic void model_reset();
      for (int c = 0; c < NCH; c++) begin
         mc[c][0] = 65536;
         for (int k = 1; k < 5; k++) mc[c][k] = 0;
         hx1[c] = 0; hx2[c] = 0; hy1[c] = 0; hy2[c] = 0;
      end
   endfunction

   function automatic void model_clear(input int c);
      hx1[c] = 0; hx2[c] = 0; hy1[c] = 0; hy2[c] = 0;
   endfunction

   function automatic void model_step(input int c, input longint x, output longint y, output bit s);
      longint a;
      longint r;
      a = mc[c][0] * x + mc[c][1] * hx1[c] + mc[c][2] * hx2[c]
          - mc[c][3] * hy1[c] - mc[c][4] * hy2[c];
      r = (a + 32768) >>> 16;
      s = 1'b0;
      if (r > 8388607)       begin r = 8388607;  s = 1'b1; end
      else if (r < -8388608) begin r = -8388608; s = 1'b1; end
      hx2[c] = hx1[c]; hx1[c] = x;
      hy2[c] = hy1[c]; hy1[c] = r;
      y = r;
   endfunction

   // Output checker: every cycle out_valid is high, the held result must be
   // the oldest outstanding model result; it retires on the handshake.
   always @(negedge clk) begin
      if (reset && bus.out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out_valid", 1, 0);
         end else begin
            check("out_data", bus.out_data, exp_q[0].y);
            check("out_ch", bus.out_ch, exp_q[0].ch);
            check("out_sat", bus.out_sat, exp_q[0].sat);
            if (bus.out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("in_ready_timeout", n, 0);
   endtask

   task automatic write_coef(input int c, input int sel, input longint v);
      @(negedge clk);
      wait_idle();
      bus.coef_we   = 1'b1;
      bus.coef_ch   = 2'(c);
      bus.coef_sel  = 3'(sel);
      bus.coef_data = v[23:0];
      @(posedge clk);
      #1 bus.coef_we = 1'b0;
      mc[c][sel] = sext24(v);
   endtask

   task automatic clear(input int c);
      @(negedge clk);
      wait_idle();
      bus.clear_ch = 1'b1;
      bus.coef_ch  = 2'(c);
      @(posedge clk);
      #1 bus.clear_ch = 1'b0;
      model_clear(c);
   endtask

   // Sends one sample, checks busy/latency and a hand-computed literal.
   task automatic send(input int c, input longint x, input longint lit, input bit lit_sat,
                       input bit clr = 1'b0, input bit we = 1'b0, input int sel = 0,
                       input longint cv = 0);
      exp_t e;
      int   k;
      @(negedge clk);
      wait_idle();
      bus.in_ch    = 2'(c);
      bus.in_data  = x[23:0];
      bus.in_valid = 1'b1;
      if (we) begin
         bus.coef_we   = 1'b1;
         bus.coef_ch   = 2'(c);
         bus.coef_sel  = 3'(sel);
         bus.coef_data = cv[23:0];
         mc[c][sel]    = sext24(cv);
      end
      if (clr) begin
         bus.clear_ch = 1'b1;
         bus.coef_ch  = 2'(c);
         model_clear(c);
      end
      e.ch = c;
      model_step(c, x, e.y, e.sat);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.coef_we  = 1'b0;
      bus.clear_ch = 1'b0;
      @(negedge clk);
      check("in_ready_busy", bus.in_ready, 0);
      k = 0;
      while (bus.out_valid !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("latency", k, 6);
      check("literal_data", bus.out_data, lit);
      check("literal_sat", bus.out_sat, lit_sat);
   endtask

   initial begin
      int seen;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_ch     = '0;
      bus.out_ready = 1'b1;
      bus.coef_we   = 1'b0;
      bus.coef_ch   = '0;
      bus.coef_sel  = '0;
      bus.coef_data = '0;
      bus.clear_ch  = 1'b0;
      model_reset();

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_ch", bus.out_ch, 0);
      check("rst_out_sat", bus.out_sat, 0);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("in_ready_after_reset", bus.in_ready, 1);

      // Identity on ch0
      send(0, 1000, 1000, 0);
      send(0, -5, -5, 0);
      send(0, 8388607, 8388607, 0);

      // Impulse response on ch1
      write_coef(1, 0, 'h008000);
      write_coef(1, 1, 'h004000);
      write_coef(1, 3, 'hFF8000);
      send(1, 65536, 32768, 0);
      send(1, 0, 32768, 0);
      send(1, 0, 16384, 0);
      send(1, 0, 8192, 0);

      // Rounding half up on ch2 (b0 = 0.5)
      write_coef(2, 0, 'h008000);
      send(2, 3, 2, 0);
      send(2, -3, -1, 0);

      // Saturation on ch2 (b0 = 2.0)
      write_coef(2, 0, 'h020000);
      send(2, 6291456, 8388607, 1);
      send(2, -6291456, -8388608, 1);
      send(2, 0, 0, 0);

      // b2 and a2 paths on ch3 (b2 = 1.0, a2 = 0.5)
      write_coef(3, 2, 'h010000);
      write_coef(3, 4, 'h008000);
      send(3, 100, 100, 0);
      send(3, 0, 0, 0);
      send(3, 0, 50, 0);
      // Coefficient write in the accept cycle: b0 = 3.0 used immediately
      send(3, 10, 30, 0, 1'b0, 1'b1, 0, 'h030000);

      // Channel independence: ch1 impulse interleaved with ch0 identity
      clear(1);
      send(1, 65536, 32768, 0);
      send(0, 7, 7, 0);
      send(1, 0, 32768, 0);
      send(0, -7, -7, 0);
      send(1, 0, 16384, 0);
      send(0, 0, 0, 0);
      send(1, 0, 8192, 0);
      // Clear and accept of ch1 in the same cycle: zero history wins
      send(1, 0, 0, 0, 1'b1);

      // Backpressure with an ignored coefficient write
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      send(0, 42, 42, 0);
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            bus.coef_we   = 1'b1;
            bus.coef_ch   = 2'd0;
            bus.coef_sel  = 3'd0;
            bus.coef_data = 24'h020000;
         end
         if (i == 4) bus.coef_we = 1'b0;
         check("bp_in_ready", bus.in_ready, 0);
         check("bp_out_valid", bus.out_valid, 1);
         check("bp_out_data", bus.out_data, 42);
         @(negedge clk);
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      send(0, 42, 42, 0);

      // Reset while the MAC is at tap 2
      @(negedge clk);
      wait_idle();
      bus.in_ch    = 2'd1;
      bus.in_data  = 24'd500;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      model_reset();
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) seen++;
      end
      check("no_out_after_abort", seen, 0);
      check("busy_after_abort", bus.busy, 0);
      send(1, 12345, 12345, 0);
      send(2, -777, -777, 0);
      send(3, 5, 5, 0);
      send(1, 0, 0, 0);

      @(negedge clk);
      @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
